// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed hex driver for a common-anode multi-digit
// seven-segment display. Scans one digit per CLK_DIV-cycle slot, blanks the
// first BLANK_CYC cycles of each slot against ghosting, and swaps in newly
// loaded values only at frame boundaries so a frame never shows mixed data.
// All outputs are active-low and registered (one cycle behind the scan state).
//
// Optional build macro SEG7_LZ_BLANK_EN: leading-zero suppression on the
// displayed value (anodes still scan, only the segments are blanked).
module seg7_scan_mux #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  load_i,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CntMax   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BlankEnd = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IdxMax   = IW'(DIGITS - 1);

    // Active-low glyph for one hex nibble, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: ;
        endcase
    endfunction

    // Scan state
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  slot_end;
    logic                  frame_end;

    // Double-buffered value: pending (written by load) and display (scanned)
    logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [4*DIGITS-1:0]   disp_data_q, disp_data_d;
    logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;

    // Registered outputs
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_q;

    // Digit currently selected by the scan index
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;

    // Digits whose segments are suppressed as leading zeros
    logic [DIGITS-1:0]     lz_mask;

    assign slot_end  = (cnt_q == CntMax);
    assign frame_end = slot_end && (idx_q == IdxMax);

    // Prescaler and digit index next-state.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + IW'(1);
        end
    end

    // Pending/display buffering: the frame boundary moves the old pending
    // value first, then a coincident load refills pending for next frame.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_vld_d  = pend_vld_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        if (frame_end && pend_vld_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
            pend_vld_d  = 1'b0;
        end
        if (load_i) begin
            pend_data_d = data_i;
            pend_dp_d   = dp_i;
            pend_vld_d  = 1'b1;
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic zero_run;

    // Walk down from the top digit; a digit is a leading zero while every
    // digit from the top down to it is zero. A set dp keeps it visible.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (disp_data_q[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run && !disp_dp_q[k];
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Select the nibble, dp and suppression flag for the current index.
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib = disp_data_q[4*k +: 4];
                cur_dp  = disp_dp_q[k];
                cur_lz  = lz_mask[k];
            end
        end
    end

    // Output next-state: blank during the guard interval, else drive digit.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (cnt_q >= BlankEnd) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx_q == IW'(k)) begin
                    an_d[k] = 1'b0;
                end
            end
            seg_d = cur_lz ? 7'h7F : glyph(cur_nib);
            dp_d  = ~cur_dp;
        end
    end

    // Scan counters and value buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            pend_vld_q  <= 1'b0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_data_q <= pend_data_d;
            pend_dp_q   <= pend_dp_d;
            pend_vld_q  <= pend_vld_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
        end
    end

    // Output registers; the frame pulse lands on the cycle after frame_end.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= '1;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_end;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised, time-multiplexed hex display driver for a common-anode multi-digit seven-segment module.
- Holds DIGITS nibbles and scans one digit per refresh slot, with active-low segment, decimal-point and anode outputs.
- Provides tear-free frame-synchronous updates and an anti-ghosting blank interval.
- Sits between the application's value registers and the board display pins; replaces the single-digit combinational hex decoder.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- CLK_DIV, 50000, clock cycles per digit slot (>= 2).
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off (< CLK_DIV).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_i  in  4*DIGITS  hex nibbles; digit k = data_i[4k+3:4k], digit 0 is rightmost.
- dp_i  in  DIGITS  decimal-point request per digit, active-high.
- load_i  in  1  one-cycle strobe; captures data_i and dp_i into the pending register.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  out  1  decimal point, active-low.
- an_o  out  DIGITS  digit anode enables, active-low, one-hot-low when active.
- frame_o  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Single clock domain. rst is synchronous, active-high.
- Reset values:
  - prescaler = 0, digit index = 0, pending and display registers = 0, pending-valid = 0.
  - seg_o = 7'h7F, dp_o = 1, an_o = all 1s, frame_o = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - slot_end is asserted when prescaler == CLK_DIV-1.
- Digit index:
  - Increments on slot_end and wraps from DIGITS-1 to 0.
  - frame_end = slot_end AND index == DIGITS-1.
- Load:
  - load_i writes the pending register and sets pending-valid.
  - A later load_i before the frame boundary overwrites it; the last load wins.
- Frame update:
  - On frame_end with pending-valid set, pending is copied to the display register and pending-valid is cleared.
  - If load_i coincides with frame_end, the new data_i goes to pending only. It reaches the display at the following frame boundary; the old pending value is transferred this frame.
- Output timing:
  - All outputs are registered and reflect the prescaler and index of the previous cycle (1-cycle latency).
- Blank interval:
  - While prescaler < BLANK_CYC, an_o = all 1s, seg_o = 7'h7F, dp_o = 1.
- Active part of the slot:
  - an_o bit[index] = 0, all other bits = 1.
  - seg_o = inverted glyph of display nibble[index].
  - dp_o = ~display_dp[index].
- Glyphs, seg_o values:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78.
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
- frame_o pulses on the cycle after frame_end.
- Reset mid-scan returns to index 0 and prescaler 0 on the next edge. The display contents are lost.
- DIGITS == 1: the index stays 0, and every slot_end is also frame_end.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined:
  - Leading-zero suppression on the display register. A digit k > 0 is blanked (seg_o = 7'h7F) when it and all digits above it are 0.
  - Blanking is suppressed when that digit's dp is set.
  - Digit 0 is never blanked.
  - The anode still asserts, so scan timing is unchanged.
- Undefined: all digits are always shown, including leading zeros.

Test Plan:
Bench configuration for all cases: DIGITS=4, CLK_DIV=4, BLANK_CYC=1.
1. Reset check: hold rst for 3 cycles, then release. During reset, seg_o=7F, an_o=F, dp_o=1, frame_o=0. The first active slot shows an_o=E, seg_o=40 (all-zero display).
2. Load 16'h5A0F with dp_i=4'b0100 mid-frame:
   - The display is unchanged until frame_o.
   - After frame_o, the next frame produces an_o E/D/B/7 with seg_o 0E/40/08/12.
   - dp_o=0 only in the an_o=B slot.
   - The first cycle of each slot is blank (an_o=F).
3. load_i on the frame_end cycle with 16'h1111, following an earlier load of 16'h2222 in the same frame. The next frame shows 2222 (seg_o=24); the frame after shows 1111 (seg_o=79).
4. Two loads in one frame (16'h3333, then 16'h4444): only 4444 (seg_o=19) is displayed.
5. Assert rst during the an_o=B slot: the next cycle gives an_o=F and seg_o=7F, and scanning restarts at digit 0 with a zeroed display.
6. With SEG7_LZ_BLANK_EN, load 16'h0070: digits 3 and 2 show seg_o=7F while their anodes still assert; digit 1 shows 78 and digit 0 shows 40. Without the macro, digits 3 and 2 show 40.
